// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer that shares one ALU between two clients.
// The winner's operands are latched into the ALU, the arbiter waits for END
// (ignoring a stale END in the first BUSY cycle), and the result goes back to
// the owner with a one-cycle done pulse. If END never arrives, the arbiter
// aborts with an error after TIMEOUT cycles.
module alu_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req0,
  input  logic        req1,
  input  logic [7:0]  x0,
  input  logic [7:0]  x1,
  input  logic [7:0]  y0,
  input  logic [7:0]  y1,
  input  logic [2:0]  op0,
  input  logic [2:0]  op1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [15:0] result0,
  output logic [15:0] result1,
  output logic [1:0]  grant,
  output logic        busy,
  output logic [7:0]  alu_X,
  output logic [7:0]  alu_Y,
  output logic [2:0]  alu_op,
  output logic        alu_BEGIN,
  input  logic [15:0] alu_OUT,
  input  logic        alu_END
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      state_next;
  logic        owner;   // client currently holding the ALU
  logic        last;    // client served most recently
  logic [15:0] cnt;     // cycles spent in BUSY, 0 during the first one
  logic        take;    // IDLE grants a client this cycle
  logic        pick;    // client chosen by arbitration
  logic        fin_ok;  // END accepted
  logic        fin_to;  // timeout abort

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, arbitration, and state-derived outputs
  always_comb begin
    state_next = state;
    take       = 1'b0;
    pick       = 1'b0;
    fin_ok     = 1'b0;
    fin_to     = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          take       = 1'b1;
          pick       = (req0 && req1) ? ~last : req1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        // cnt == 0 marks the first BUSY cycle, in which END may be stale
        if (alu_END && (cnt != '0)) begin
          fin_ok     = 1'b1;
          state_next = DONE;
        end else if (cnt == CNT_LAST) begin
          fin_to     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    alu_BEGIN = (state == BUSY);
    busy      = (state != IDLE);
    grant     = (state == IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);
    done0     = (state == DONE) && !owner;
    done1     = (state == DONE) && owner;
  end

  // Operand latch, timeout counter, result/error capture, and round-robin pointer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner   <= 1'b0;
      last    <= 1'b1;
      cnt     <= '0;
      alu_X   <= '0;
      alu_Y   <= '0;
      alu_op  <= '0;
      result0 <= '0;
      result1 <= '0;
      err0    <= 1'b0;
      err1    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            owner  <= pick;
            cnt    <= '0;
            alu_X  <= pick ? x1  : x0;
            alu_Y  <= pick ? y1  : y0;
            alu_op <= pick ? op1 : op0;
          end
        end
        BUSY: begin
          cnt <= cnt + 16'd1;
          if (fin_ok || fin_to) begin
            if (owner) begin
              result1 <= fin_ok ? alu_OUT : '0;
              err1    <= fin_to;
            end else begin
              result0 <= fin_ok ? alu_OUT : '0;
              err0    <= fin_to;
            end
          end
        end
        DONE: begin
          last <= owner;
        end
        default: begin
          last <= last;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural ALU that
// raises END a programmable number of cycles after BEGIN and returns X*Y.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req0, req1;
  logic [7:0]  x0, x1, y0, y1;
  logic [2:0]  op0, op1;
  logic        done0, done1, err0, err1;
  logic [15:0] result0, result1;
  logic [1:0]  grant;
  logic        busy;
  logic [7:0]  alu_X, alu_Y;
  logic [2:0]  alu_op;
  logic        alu_BEGIN;
  logic [15:0] alu_OUT;
  logic        alu_END = 1'b0;

  int errors = 0;
  int checks = 0;

  // ALU model controls: lat = cycles from BEGIN to END (0 = never)
  int lat        = 0;
  bit end_always = 1'b0;
  int bcnt       = 0;

  alu_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .resetn(resetn),
    .req0(req0), .req1(req1),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .op0(op0), .op1(op1),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .result0(result0), .result1(result1),
    .grant(grant), .busy(busy),
    .alu_X(alu_X), .alu_Y(alu_Y), .alu_op(alu_op), .alu_BEGIN(alu_BEGIN),
    .alu_OUT(alu_OUT), .alu_END(alu_END)
  );

  always #5 clk = ~clk;

  // Behavioural ALU, updated on the falling edge away from the DUT's sampling edge
  always @(negedge clk) begin
    if (alu_BEGIN) bcnt = bcnt + 1;
    else bcnt = 0;
    alu_END = end_always || (lat > 0 && alu_BEGIN && bcnt >= lat);
  end

  assign alu_OUT = {8'd0, alu_X} * {8'd0, alu_Y};

  task automatic wait_done(input int idx, input int maxc, output int cycles);
    cycles = maxc + 1;
    for (int c = 1; c <= maxc; c++) begin
      @(posedge clk); #1;
      if ((idx == 0 && done0) || (idx == 1 && done1)) begin
        cycles = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    req0 = 0; req1 = 0; x0 = 0; x1 = 0; y0 = 0; y1 = 0; op0 = 0; op1 = 0;
    #2;
    checks++;
    if ({done0, done1, err0, err1, result0, result1, grant, busy, alu_X, alu_Y, alu_op, alu_BEGIN} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got done=%b%b err=%b%b r0=%h r1=%h grant=%b busy=%b X=%h Y=%h op=%h BEGIN=%b, want all 0",
               done1, done0, err1, err0, result0, result1, grant, busy, alu_X, alu_Y, alu_op, alu_BEGIN);
    end
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_tie;
    int cyc;
    lat = 2;
    x0 = 8'd1; y0 = 8'd1; x1 = 8'd6; y1 = 8'd7;
    req0 = 1; req1 = 1;
    @(posedge clk); #1;
    checks++;
    if (grant !== 2'b01) begin errors++; $display("FAIL tie_first_grant: got %b want 01", grant); end
    wait_done(0, 20, cyc);
    checks++;
    if (cyc !== 2 || done1 !== 1'b0 || result0 !== 16'd1) begin
      errors++; $display("FAIL tie_done0: got cyc=%0d done1=%b r0=%h want cyc=2 done1=0 r0=0001", cyc, done1, result0);
    end
    @(posedge clk); #1; req0 = 0;
    @(posedge clk); #1;
    checks++;
    if (grant !== 2'b10) begin errors++; $display("FAIL tie_second_grant: got %b want 10", grant); end
    wait_done(1, 20, cyc);
    checks++;
    if (cyc !== 2 || result1 !== 16'd42 || err1 !== 1'b0) begin
      errors++; $display("FAIL tie_done1: got cyc=%0d r1=%h err1=%b want cyc=2 r1=002a err1=0", cyc, result1, err1);
    end
    @(posedge clk); #1; req1 = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin;
    int cyc;
    int exp;
    bit got;
    lat = 3;
    x0 = 8'd3; y0 = 8'd7; x1 = 8'd5; y1 = 8'd9;
    req0 = 1; req1 = 1;
    for (int i = 0; i < 6; i++) begin
      exp = i % 2;
      got = 0;
      for (int c = 0; c < 6 && !got; c++) begin
        @(posedge clk); #1;
        if (grant != 2'b00) got = 1;
      end
      checks++;
      if (grant !== (exp == 1 ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL rr_grant[%0d]: got %b want client %0d", i, grant, exp);
      end
      wait_done(exp, 20, cyc);
      checks++;
      if (cyc !== 3 || (exp == 0 ? result0 !== 16'd21 : result1 !== 16'd45)) begin
        errors++; $display("FAIL rr_done[%0d]: got cyc=%0d r0=%h r1=%h want cyc=3 r%0d=%h",
                           i, cyc, result0, result1, exp, (exp == 0) ? 16'd21 : 16'd45);
      end
    end
    @(posedge clk); #1; req0 = 0; req1 = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    int cyc;
    lat = 4;
    x0 = 8'd2; y0 = 8'd10; op0 = 3'b101; req0 = 1;
    @(posedge clk); #1;
    checks++;
    if (grant !== 2'b01 || alu_BEGIN !== 1'b1 || alu_X !== 8'd2 || alu_Y !== 8'd10 || alu_op !== 3'b101) begin
      errors++; $display("FAIL single_issue: got grant=%b BEGIN=%b X=%h Y=%h op=%b want 01 1 02 0a 101",
                         grant, alu_BEGIN, alu_X, alu_Y, alu_op);
    end
    wait_done(0, 20, cyc);
    checks++;
    if (cyc !== 4 || result0 !== 16'h0014 || err0 !== 1'b0 || done1 !== 1'b0 || alu_BEGIN !== 1'b0) begin
      errors++; $display("FAIL single_done: got cyc=%0d r0=%h err0=%b done1=%b BEGIN=%b want 4 0014 0 0 0",
                         cyc, result0, err0, done1, alu_BEGIN);
    end
    @(posedge clk); #1; req0 = 0;
    checks++;
    if (done0 !== 1'b0 || grant !== 2'b00) begin
      errors++; $display("FAIL single_pulse: got done0=%b grant=%b want 0 00", done0, grant);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout;
    int cyc;
    lat = 0;
    x0 = 8'd4; y0 = 8'd4; req0 = 1;
    @(posedge clk); #1;
    checks++;
    if (alu_BEGIN !== 1'b1) begin errors++; $display("FAIL timeout_begin: got %b want 1", alu_BEGIN); end
    wait_done(0, 20, cyc);
    checks++;
    if (cyc !== 8 || err0 !== 1'b1 || result0 !== 16'd0) begin
      errors++; $display("FAIL timeout_abort: got cyc=%0d err0=%b r0=%h want 8 1 0000", cyc, err0, result0);
    end
    @(posedge clk); #1; req0 = 0;
    lat = 2;
    @(posedge clk); #1; req0 = 1;
    @(posedge clk); #1;
    wait_done(0, 20, cyc);
    checks++;
    if (cyc !== 2 || err0 !== 1'b0 || result0 !== 16'd16) begin
      errors++; $display("FAIL timeout_recover: got cyc=%0d err0=%b r0=%h want 2 0 0010", cyc, err0, result0);
    end
    @(posedge clk); #1; req0 = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_stale_end;
    int cyc;
    end_always = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done0 !== 1'b0 || done1 !== 1'b0 || grant !== 2'b00) begin
        errors++; $display("FAIL stale_idle[%0d]: got busy=%b done=%b%b grant=%b want all 0", i, busy, done1, done0, grant);
      end
    end
    x1 = 8'd2; y1 = 8'd3; req1 = 1;
    @(posedge clk); #1;
    wait_done(1, 20, cyc);
    checks++;
    if (cyc + 1 !== 3 || result1 !== 16'd6) begin
      errors++; $display("FAIL stale_done1: got latency=%0d r1=%h want 3 0006", cyc + 1, result1);
    end
    @(posedge clk); #1; req1 = 0;
    x0 = 8'd9; y0 = 8'd9; req0 = 1;
    @(posedge clk); #1;
    wait_done(0, 20, cyc);
    checks++;
    if (cyc + 1 !== 3 || result0 !== 16'd81) begin
      errors++; $display("FAIL stale_done0: got latency=%0d r0=%h want 3 0051", cyc + 1, result0);
    end
    @(posedge clk); #1; req0 = 0;
    end_always = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int cyc;
    lat = 0;
    x0 = 8'd7; y0 = 8'd8; req0 = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy: got %b want 1", busy); end
    resetn = 0;
    #1;
    checks++;
    if ({done0, done1, err0, err1, result0, result1, grant, busy, alu_X, alu_Y, alu_op, alu_BEGIN} !== '0) begin
      errors++; $display("FAIL midrst_outputs: got done=%b%b r0=%h r1=%h grant=%b busy=%b X=%h BEGIN=%b want all 0",
                         done1, done0, result0, result1, grant, busy, alu_X, alu_BEGIN);
    end
    req0 = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (done0 !== 1'b0 || done1 !== 1'b0) begin
        errors++; $display("FAIL midrst_nodone[%0d]: got done=%b%b want 00", i, done1, done0);
      end
    end
    resetn = 1;
    lat = 2;
    @(posedge clk); #1;
    x0 = 8'd1; y0 = 8'd5; x1 = 8'd2; y1 = 8'd2;
    req0 = 1; req1 = 1;
    @(posedge clk); #1;
    checks++;
    if (grant !== 2'b01) begin errors++; $display("FAIL midrst_tie: got %b want 01", grant); end
    wait_done(0, 20, cyc);
    checks++;
    if (cyc !== 2 || result0 !== 16'd5) begin
      errors++; $display("FAIL midrst_done0: got cyc=%0d r0=%h want 2 0005", cyc, result0);
    end
    @(posedge clk); #1; req0 = 0; req1 = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_tie;
    test_round_robin;
    test_single;
    test_timeout;
    test_stale_end;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
